cpu_trace_buffer: RTL and testbench
===================================

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace entries held; power of two, >= 4.
REQ-002 SHALL have parameter POST, default 8, entries captured after the trigger entry; 0 <= POST < DEPTH.
REQ-003 SHALL have parameter DW, default 32, width of pc, inst and write-back data.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port arm  in  1  single-cycle pulse that starts a capture.
REQ-007 SHALL have port trig_mode  in  2  trigger source: 00 force only, 01 pc match, 10 register-write match.
REQ-008 SHALL have ports trig_pc  in  DW  and  trig_reg  in  5  trigger compare values.
REQ-009 SHALL have port force_trig  in  1  immediate trigger, valid in every mode.
REQ-010 SHALL have ports commit_valid 1, commit_pc DW, commit_inst DW, commit_we 1, commit_waddr 5, commit_wdata DW, all inputs; one retired instruction per valid cycle.
REQ-011 SHALL have ports out_valid  out  1,  out_ready  in  1,  out_entry  out  3*DW+6,  out_last  out  1  dump stream.
REQ-012 SHALL have ports state  out  2  and  count  out  clog2(DEPTH)+1  status.

Function
REQ-013 SHALL implement states IDLE(0), PRE(1), POST(2), DUMP(3).
REQ-014 IDLE: arm SHALL go to PRE, clearing write pointer and count; commits ignored.
REQ-015 PRE/POST: each commit_valid SHALL write {pc, inst, we, waddr, wdata} at the write pointer, pointer +1 mod DEPTH, count +1 saturating at DEPTH (oldest overwritten).
REQ-016 Trigger SHALL be evaluated only in PRE on a commit_valid cycle: force_trig, or mode 01 and commit_pc==trig_pc, or mode 10 and commit_we and commit_waddr==trig_reg and trig_reg!=0.
REQ-017 The triggering commit SHALL be recorded; state SHALL go to POST with post counter loaded to POST.
REQ-018 POST: each recorded commit SHALL decrement the post counter; when the counter is 0 the state SHALL go to DUMP on the next edge (POST=0: DUMP the edge after trigger).
REQ-019 arm in PRE or POST SHALL restart the capture (pointer and count cleared, state PRE); arm in DUMP SHALL be ignored.
REQ-020 Entering DUMP, the read pointer SHALL be (write pointer - count) mod DEPTH; out_valid SHALL rise one cycle later.
REQ-021 Entries SHALL be emitted oldest first; the stream SHALL advance only on out_valid&&out_ready; out_entry SHALL be stable while out_valid&&!out_ready.
REQ-022 out_last SHALL be high with the final (count-th) entry; after its handshake state SHALL return to IDLE, out_valid low, count unchanged until next arm.
REQ-023 Back-to-back handshakes SHALL sustain one entry per cycle.
REQ-024 commit_valid in DUMP SHALL be ignored and SHALL NOT corrupt stored entries.

Reset
REQ-025 rst low SHALL immediately force state IDLE, pointers 0, count 0, post counter 0, out_valid 0, out_last 0, out_entry 0.
REQ-026 Reset mid-capture or mid-dump SHALL abort with no further output; storage contents need not be cleared.

Structure
REQ-027 Package cpu_trace_pkg SHALL hold state encodings, trig_mode encodings, entry-field widths and entry-width constant.
REQ-028 Storage SHALL be one sub-module trace_ram: DEPTH x (3*DW+6), synchronous write, one-cycle synchronous read.
REQ-029 Control FSM, pointers and counters SHALL live in cpu_trace_buffer.

Verification
REQ-030 DEPTH=16, POST=8, mode 01, trig_pc=0x00400010; commits pc 0x00400000+4k, k=0..29 -> trigger at k=4, 13 entries dumped, pc 0x00400000..0x00400030, out_last on 13th.
REQ-031 Same, trigger at k=20 -> count=16, dump starts pc 0x00400034 (k=13), ends 0x00400070 (k=28).
REQ-032 Mode 10, trig_reg=8; commit we=1 waddr=0 then waddr=8 wdata=0xDEADBEEF -> trigger on second commit; waddr=0 never triggers.
REQ-033 During dump, out_ready toggled 1,0,0,1 each cycle -> no duplicated or dropped entries, out_entry held while stalled; commits injected in DUMP do not appear.
REQ-034 POST=0, force_trig with first commit -> one entry dumped with out_last=1, then state IDLE.
REQ-035 rst low for 1 cycle during POST and during DUMP -> state 0, out_valid 0, count 0; re-arm captures normally.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU retirement trace buffer.
//   - FSM state encodings (also driven on the status port)
//   - trigger-source encodings for trig_mode
//   - write-back metadata layout and trace entry width helpers
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DUMP = 2'd3
    } trace_state_e;

    typedef enum logic [1:0] {
        TRIG_FORCE = 2'b00,
        TRIG_PC    = 2'b01,
        TRIG_REG   = 2'b10,
        TRIG_RSVD  = 2'b11
    } trig_mode_e;

    localparam int unsigned DEFAULT_DW = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WE_W       = 1;
    localparam int unsigned META_W     = WE_W + REG_ADDR_W;

    // Write-back metadata that sits between inst and wdata in an entry.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] waddr;
    } wb_meta_t;

    // Entry layout, MSB first: {pc, inst, we, waddr, wdata}.
    function automatic int unsigned entry_w(input int unsigned dw);
        return 3 * dw + META_W;
    endfunction

    localparam int unsigned ENTRY_W = entry_w(DEFAULT_DW);

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Commit bus and dump stream between the core, the trace buffer and the
// trace consumer.
//   master : the core/consumer side (drives commits and out_ready)
//   slave  : the trace buffer (drives out_valid/out_entry/out_last)
interface cpu_trace_buffer_if
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW
);
    localparam int unsigned EW = entry_w(DW);

    // retired-instruction stream
    logic                  commit_valid;
    logic [DW-1:0]         commit_pc;
    logic [DW-1:0]         commit_inst;
    logic                  commit_we;
    logic [REG_ADDR_W-1:0] commit_waddr;
    logic [DW-1:0]         commit_wdata;

    // dump stream
    logic                  out_valid;
    logic                  out_ready;
    logic [EW-1:0]         out_entry;
    logic                  out_last;

    modport master (
        output commit_valid, commit_pc, commit_inst,
        output commit_we, commit_waddr, commit_wdata,
        output out_ready,
        input  out_valid, out_entry, out_last
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst,
        input  commit_we, commit_waddr, commit_wdata,
        input  out_ready,
        output out_valid, out_entry, out_last
    );

endinterface

// File: rtl/cpu_trace_buffer_trace_ram.sv
// trace_ram: DEPTH x WIDTH storage for trace entries.
//   clk, rst             : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data: synchronous write port
//   rd_en/rd_addr        : read request, data appears on rd_data next edge
//   rd_data              : registered read data, holds while rd_en is low
module trace_ram #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 102,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register doubles as the dump output register, so it is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of retired instructions around a
// trigger, then an oldest-first dump over a valid/ready stream.
//   clk, rst        : clock, async active-low reset
//   arm             : pulse to start (or restart) a capture
//   trig_mode       : 00 force only, 01 pc match, 10 register-write match
//   trig_pc/trig_reg: trigger compare values
//   force_trig      : immediate trigger in any mode
//   bus             : commit stream in, dump stream out (slave side)
//   state, count    : FSM state and number of valid entries held
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned POST  = 8,
    parameter  int unsigned DW    = DEFAULT_DW,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1,
    localparam int unsigned EW    = entry_w(DW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [1:0]            trig_mode,
    input  logic [DW-1:0]         trig_pc,
    input  logic [REG_ADDR_W-1:0] trig_reg,
    input  logic                  force_trig,
    cpu_trace_buffer_if.slave     bus,
    output logic [1:0]            state,
    output logic [CW-1:0]         count
);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW-1:0] post_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] left_q;
    logic          out_valid_q;
    logic          out_last_q;

    logic          trig_match_c;
    logic          restart_c;
    logic          wr_en_c;
    logic          trig_hit_c;
    logic          dump_start_c;
    logic          fetch_c;
    logic          done_c;
    wb_meta_t      meta_c;
    logic [EW-1:0] wr_data_c;

    // Trigger condition for the current commit; only consulted in PRE.
    assign trig_match_c = force_trig
                       || ((trig_mode == TRIG_PC) && (bus.commit_pc == trig_pc))
                       || ((trig_mode == TRIG_REG) && bus.commit_we
                           && (bus.commit_waddr == trig_reg)
                           && (trig_reg != '0));

    assign meta_c    = '{we: bus.commit_we, waddr: bus.commit_waddr};
    assign wr_data_c = {bus.commit_pc, bus.commit_inst, meta_c, bus.commit_wdata};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        state_d      = state_q;
        restart_c    = 1'b0;
        wr_en_c      = 1'b0;
        trig_hit_c   = 1'b0;
        dump_start_c = 1'b0;
        fetch_c      = 1'b0;
        done_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    restart_c = 1'b1;
                    state_d   = ST_PRE;
                end
            end
            ST_PRE: begin
                if (arm) begin
                    restart_c = 1'b1;
                end else if (bus.commit_valid) begin
                    wr_en_c = 1'b1;
                    if (trig_match_c) begin
                        trig_hit_c = 1'b1;
                        state_d    = ST_POST;
                    end
                end
            end
            ST_POST: begin
                // Counter at zero means the post window is full: commits
                // arriving in this cycle are not recorded.
                if (arm) begin
                    restart_c = 1'b1;
                    state_d   = ST_PRE;
                end else if (post_q == '0) begin
                    dump_start_c = 1'b1;
                    state_d      = ST_DUMP;
                end else if (bus.commit_valid) begin
                    wr_en_c = 1'b1;
                end
            end
            ST_DUMP: begin
                // A fetch loads the output register; the first one happens
                // unconditionally on the first DUMP cycle.
                if (!out_valid_q) begin
                    fetch_c = 1'b1;
                end else if (bus.out_ready) begin
                    if (out_last_q) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fetch_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointers, counters and stream flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            post_q      <= '0;
            cnt_q       <= '0;
            left_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (restart_c) begin
                wptr_q <= '0;
                cnt_q  <= '0;
                post_q <= '0;
            end else begin
                if (wr_en_c) begin
                    wptr_q <= wptr_q + AW'(1);
                    if (cnt_q != CW'(DEPTH)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                if (trig_hit_c) begin
                    post_q <= AW'(POST);
                end else if (wr_en_c && (state_q == ST_POST)) begin
                    post_q <= post_q - AW'(1);
                end
            end

            // A full buffer has cnt low bits of zero, so start == wptr.
            if (dump_start_c) begin
                rptr_q <= wptr_q - cnt_q[AW-1:0];
                left_q <= cnt_q;
            end else if (fetch_c) begin
                rptr_q <= rptr_q + AW'(1);
                left_q <= left_q - CW'(1);
            end

            if (fetch_c) begin
                out_valid_q <= 1'b1;
                out_last_q  <= (left_q == CW'(1));
            end else if (done_c) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_trace_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_addr (wptr_q),
        .wr_data (wr_data_c),
        .rd_en   (fetch_c),
        .rd_addr (rptr_q),
        .rd_data (bus.out_entry)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign state         = state_q;
    assign count         = cnt_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer. Two instances share stimulus:
// dut_a (DEPTH=16, POST=8) and dut_b (DEPTH=4, POST=0); sel picks which one
// is armed and observed. Expected dumps come from a queue model of the
// capture rules.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned EW   = 3 * DW + 6;
    localparam int unsigned SMAX = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        arm;
    logic [1:0]  trig_mode;
    logic [31:0] trig_pc;
    logic [4:0]  trig_reg;
    logic        force_trig;
    logic        c_valid, c_we, ready;
    logic [31:0] c_pc, c_inst, c_wdata;
    logic [4:0]  c_waddr;

    logic [1:0]  state_a, state_b;
    logic [4:0]  count_a;
    logic [2:0]  count_b;

    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.DW(DW)) bus_a ();
    cpu_trace_buffer_if #(.DW(DW)) bus_b ();

    assign bus_a.commit_valid = c_valid;
    assign bus_a.commit_pc    = c_pc;
    assign bus_a.commit_inst  = c_inst;
    assign bus_a.commit_we    = c_we;
    assign bus_a.commit_waddr = c_waddr;
    assign bus_a.commit_wdata = c_wdata;
    assign bus_a.out_ready    = ready;
    assign bus_b.commit_valid = c_valid;
    assign bus_b.commit_pc    = c_pc;
    assign bus_b.commit_inst  = c_inst;
    assign bus_b.commit_we    = c_we;
    assign bus_b.commit_waddr = c_waddr;
    assign bus_b.commit_wdata = c_wdata;
    assign bus_b.out_ready    = ready;

    cpu_trace_buffer #(.DEPTH(16), .POST(8), .DW(DW)) dut_a (
        .clk(clk), .rst(rst), .arm(arm && !sel), .trig_mode(trig_mode),
        .trig_pc(trig_pc), .trig_reg(trig_reg), .force_trig(force_trig),
        .bus(bus_a), .state(state_a), .count(count_a)
    );

    cpu_trace_buffer #(.DEPTH(4), .POST(0), .DW(DW)) dut_b (
        .clk(clk), .rst(rst), .arm(arm && sel), .trig_mode(trig_mode),
        .trig_pc(trig_pc), .trig_reg(trig_reg), .force_trig(force_trig),
        .bus(bus_b), .state(state_b), .count(count_b)
    );

    logic          o_valid, o_last;
    logic [EW-1:0] o_entry;
    logic [1:0]    o_state;
    logic [7:0]    o_count;
    assign o_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign o_last  = sel ? bus_b.out_last  : bus_a.out_last;
    assign o_entry = sel ? bus_b.out_entry : bus_a.out_entry;
    assign o_state = sel ? state_b : state_a;
    assign o_count = sel ? 8'(count_b) : 8'(count_a);

    // stimulus table for one capture
    logic        s_valid [SMAX];
    logic        s_force [SMAX];
    logic        s_arm   [SMAX];
    logic        s_we    [SMAX];
    logic [31:0] s_pc    [SMAX];
    logic [31:0] s_inst  [SMAX];
    logic [31:0] s_wdata [SMAX];
    logic [4:0]  s_waddr [SMAX];

    // reference model: recorded entries, newest at the back
    logic [EW-1:0] m_q[$];
    int  m_phase;   // 0 collecting before trigger, 1 after trigger
    int  m_left;    // post-trigger commits still to record
    int  m_depth, m_post;
    bit  m_done;

    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        arm = 1'b0; force_trig = 1'b0; c_valid = 1'b0; c_we = 1'b0;
        c_pc = '0; c_inst = '0; c_wdata = '0; c_waddr = '0; ready = 1'b0;
    endtask

    task automatic drive_junk();
        c_valid = 1'($urandom); c_we = 1'($urandom); force_trig = 1'($urandom);
        c_pc = $urandom; c_inst = $urandom; c_wdata = $urandom; c_waddr = 5'($urandom);
    endtask

    task automatic select_dut(input logic s);
        sel     = s;
        m_depth = s ? 4 : 16;
        m_post  = s ? 0 : 8;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < int'(SMAX); i++) begin
            s_valid[i] = 1'b1; s_force[i] = 1'b0; s_arm[i] = 1'b0; s_we[i] = 1'($urandom);
            s_pc[i] = $urandom; s_inst[i] = $urandom; s_wdata[i] = $urandom;
            s_waddr[i] = 5'($urandom);
        end
    endtask

    task automatic gen_random();
        clear_stim();
        for (int i = 0; i < 90; i++) begin
            s_valid[i] = (i >= 55) ? 1'b1 : ($urandom_range(0, 9) < 7);
            s_pc[i]    = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            s_waddr[i] = 5'($urandom_range(0, 7));
        end
        s_force[$urandom_range(0, 30)]  = 1'b1;
        s_force[$urandom_range(55, 60)] = 1'b1;
        if ($urandom_range(0, 1) == 1) s_arm[$urandom_range(1, 50)] = 1'b1;
        trig_mode = 2'($urandom);
        trig_pc   = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        trig_reg  = 5'($urandom_range(0, 7));
    endtask

    function automatic logic [EW-1:0] pack_entry(input int i);
        return {s_pc[i], s_inst[i], s_we[i], s_waddr[i], s_wdata[i]};
    endfunction

    function automatic bit is_trigger(input int i);
        return s_force[i]
            || (trig_mode == 2'b01 && s_pc[i] == trig_pc)
            || (trig_mode == 2'b10 && s_we[i] && s_waddr[i] == trig_reg && trig_reg != 5'd0);
    endfunction

    // One commit cycle applied to the model.
    task automatic model_step(input int i);
        if (s_arm[i]) begin
            m_q.delete();
            m_phase = 0;
            m_left  = 0;
        end else if (s_valid[i]) begin
            if (m_phase == 0) begin
                m_q.push_back(pack_entry(i));
                if (is_trigger(i)) begin
                    m_phase = 1;
                    m_left  = m_post;
                end
            end else if (m_left > 0) begin
                m_q.push_back(pack_entry(i));
                m_left--;
            end
        end
        if (m_q.size() > m_depth) void'(m_q.pop_front());
        m_done = (m_phase == 1) && (m_left == 0);
    endtask

    task automatic pulse_reset(input string tag);
        drive_idle();
        rst = 1'b0;
        #1;
        chk_eq({tag, "_state"}, 128'(o_state), 128'(0));
        chk_eq({tag, "_valid"}, 128'(o_valid), 128'(0));
        chk_eq({tag, "_count"}, 128'(o_count), 128'(0));
        chk_eq({tag, "_last"},  128'(o_last),  128'(0));
        chk_eq({tag, "_entry"}, 128'(o_entry), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_q.delete(); m_phase = 0; m_left = 0; m_done = 0;
        repeat (3) begin
            tick();
            chk_eq({tag, "_quiet"}, 128'(o_valid), 128'(0));
        end
    endtask

    function automatic logic ready_val(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
        return 1'($urandom);
    endfunction

    task automatic drain(input int ready_mode, input bit arm_in_dump, input int rst_at);
        int            n     = m_q.size();
        int            idx   = 0;
        int            cyc   = 0;
        bit            stall = 0;
        logic [EW-1:0] prev  = '0;
        while (idx < n && cyc < 400) begin
            if (stall) begin
                chk_eq("hold_valid", 128'(o_valid), 128'(1));
                chk_eq("hold_entry", 128'(o_entry), 128'(prev));
            end
            ready = ready_val(ready_mode, cyc);
            drive_junk();
            arm = arm_in_dump && (cyc == 2);
            if (o_valid && ready) begin
                chk_eq("dump_entry", 128'(o_entry), 128'(m_q[idx]));
                chk_eq("dump_last",  128'(o_last),  128'(idx == n - 1));
                idx++;
            end
            stall = o_valid && !ready;
            prev  = o_entry;
            tick();
            cyc++;
            if (rst_at > 0 && idx == rst_at) begin
                pulse_reset("rst_dump");
                return;
            end
        end
        drive_idle();
        chk_eq("dump_complete", 128'(idx), 128'(n));
        chk_eq("end_state", 128'(o_state), 128'(0));
        chk_eq("end_valid", 128'(o_valid), 128'(0));
        chk_eq("end_last",  128'(o_last),  128'(0));
        chk_eq("end_count", 128'(o_count), 128'(n));
    endtask

    task automatic run_capture(input int len, input int ready_mode, input bit arm_in_dump,
                               input bit rst_in_post, input int rst_at);
        drive_junk();
        arm = 1'b1;
        tick();
        m_q.delete(); m_phase = 0; m_left = 0; m_done = 0;
        chk_eq("armed_state", 128'(o_state), 128'(1));
        chk_eq("armed_count", 128'(o_count), 128'(0));
        for (int i = 0; i < len; i++) begin
            c_valid = s_valid[i]; c_pc = s_pc[i]; c_inst = s_inst[i];
            c_we = s_we[i]; c_waddr = s_waddr[i]; c_wdata = s_wdata[i];
            force_trig = s_force[i]; arm = s_arm[i];
            model_step(i);
            tick();
            if (rst_in_post && m_phase == 1 && !m_done) begin
                chk_eq("post_state", 128'(o_state), 128'(2));
                pulse_reset("rst_post");
                return;
            end
            if (m_done) break;
        end
        if (!m_done) begin
            chk_eq("capture_done", 128'(m_done), 128'(1));
            drive_idle();
            return;
        end
        chk_eq("post_end_state", 128'(o_state), 128'(2));
        drive_junk();
        arm = 1'b0;
        tick();
        chk_eq("dump_state", 128'(o_state), 128'(3));
        chk_eq("dump_count", 128'(o_count), 128'(m_q.size()));
        chk_eq("dump_valid_delay", 128'(o_valid), 128'(0));
        drain(ready_mode, arm_in_dump, rst_at);
    endtask

    task automatic pc_ramp(input int len);
        clear_stim();
        for (int k = 0; k < len; k++) s_pc[k] = 32'h0040_0000 + 32'(4 * k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive_idle();
        select_dut(1'b0);
        trig_mode = 2'b00; trig_pc = '0; trig_reg = '0;
        repeat (2) tick();
        chk_eq("rst_state", 128'(o_state), 128'(0));
        chk_eq("rst_count", 128'(o_count), 128'(0));
        chk_eq("rst_valid", 128'(o_valid), 128'(0));
        chk_eq("rst_last",  128'(o_last),  128'(0));
        chk_eq("rst_entry", 128'(o_entry), 128'(0));
        rst = 1'b1;
        tick();

        // pc trigger early: 13 entries pc 0x00400000..0x00400030
        trig_mode = 2'b01; trig_pc = 32'h0040_0010;
        pc_ramp(30);
        run_capture(30, 0, 0, 0, 0);

        // pc trigger late: wrap, 16 entries from k=13, stall pattern, arm in dump
        trig_pc = 32'h0040_0050;
        pc_ramp(30);
        run_capture(30, 1, 1, 0, 0);

        // register-write trigger on waddr 8
        trig_mode = 2'b10; trig_reg = 5'd8;
        clear_stim();
        for (int i = 0; i < 12; i++) s_we[i] = 1'b0;
        s_we[0] = 1'b1; s_waddr[0] = 5'd0;
        s_we[1] = 1'b1; s_waddr[1] = 5'd8; s_wdata[1] = 32'hDEAD_BEEF;
        run_capture(12, 2, 0, 0, 0);

        // trig_reg 0 never matches; force ends the pre window
        trig_reg = 5'd0;
        clear_stim();
        for (int i = 0; i < 20; i++) begin s_we[i] = 1'b1; s_waddr[i] = 5'd0; end
        s_force[6] = 1'b1;
        run_capture(20, 2, 0, 0, 0);

        // POST=0 instance: force on first commit gives a single entry
        select_dut(1'b1);
        trig_mode = 2'b00;
        clear_stim();
        s_force[0] = 1'b1;
        run_capture(4, 0, 0, 0, 0);

        // POST=0, DEPTH=4 wrap with pc trigger at k=6
        trig_mode = 2'b01; trig_pc = 32'h0040_0018;
        pc_ramp(10);
        run_capture(10, 2, 0, 0, 0);

        // reset during POST, then a clean capture
        select_dut(1'b0);
        trig_mode = 2'b00;
        clear_stim();
        s_force[3] = 1'b1;
        run_capture(30, 0, 0, 1, 0);
        trig_mode = 2'b01; trig_pc = 32'h0040_0010;
        pc_ramp(30);
        run_capture(30, 2, 0, 0, 0);

        // reset during DUMP, then a clean capture
        pc_ramp(30);
        run_capture(30, 0, 0, 0, 3);
        pc_ramp(30);
        run_capture(30, 1, 0, 0, 0);

        // randomized captures on both instances
        for (int r = 0; r < 12; r++) begin
            select_dut(1'($urandom));
            gen_random();
            run_capture(90, 2, 1'($urandom), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
